// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: immediate-extension modes and skid-pipe states.
package mips_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: zero, sign, upper-placed, branch offset.
module imm_extend_core
    import mips_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext_c
);

    localparam int unsigned E = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_c;

    assign sign_c = {{E{imm[IN_W-1]}}, imm};

    // Branch offset drops the top two bits of the sign-extended value.
    always_comb begin
        ext_c = '0;
        case (mode)
            MODE_ZERO:   ext_c = {{E{1'b0}}, imm};
            MODE_SIGN:   ext_c = sign_c;
            MODE_UPPER:  ext_c = {imm, {E{1'b0}}};
            MODE_BRANCH: ext_c = {sign_c[OUT_W-3:0], 2'b00};
            default:     ext_c = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with valid/ready handshake and a
// two-entry skid buffer (main register S, skid register K).
module imm_extend_pipe
    import mips_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    if (IN_W < 2) begin : g_bad_in_w
        $error("imm_extend_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_extend_pipe: OUT_W must be >= IN_W + 2");
    end

    skid_state_e      state_q, state_d;
    logic             k_valid;
    logic [OUT_W-1:0] k_data;
    logic [TAG_W-1:0] k_tag;
    logic [OUT_W-1:0] ext_c;
    logic             accept_c, fire_c;
    logic             s_load_in_c, s_load_k_c, k_load_c;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm   (in_imm),
        .mode  (in_mode),
        .ext_c (ext_c)
    );

    // Readiness depends only on skid occupancy and flush, never on out_ready.
    assign in_ready = ~k_valid & ~flush;
    assign accept_c = in_valid & in_ready;
    assign fire_c   = out_valid & out_ready;

    // Next-state and register-load decode; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        s_load_in_c = 1'b0;
        s_load_k_c  = 1'b0;
        k_load_c    = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        s_load_in_c = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (fire_c && accept_c) begin
                        s_load_in_c = 1'b1;
                    end else if (fire_c) begin
                        state_d = ST_EMPTY;
                    end else if (accept_c) begin
                        k_load_c = 1'b1;
                        state_d  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (fire_c) begin
                        s_load_k_c = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            k_valid   <= 1'b0;
            k_data    <= '0;
            k_tag     <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != ST_EMPTY);
            k_valid   <= (state_d == ST_FULL);
            if (s_load_in_c) begin
                out_data <= ext_c;
                out_tag  <= in_tag;
            end else if (s_load_k_c) begin
                out_data <= k_data;
                out_tag  <= k_tag;
            end
            if (k_load_c) begin
                k_data <= ext_c;
                k_tag  <= in_tag;
            end
        end
    end

endmodule
